// File: rtl/sdram_cmd_responder_pkg.sv
// Shared types and constants for the SDRAM command responder.
// The state enum is used by the top-level FSM. The widths are shared with the command interface.
package sdram_cmd_pkg;

    typedef enum logic [1:0] {
        Ready   = 2'd0,
        RowOpen = 2'd1,
        Refresh = 2'd2
    } state_e;

    localparam int CmdAddrWidth = 23;
    localparam int DefDataWidth = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_cmd_responder_if.sv
// Command bus between an initiator (master) and the SDRAM controller or its
// BRAM stand-in (slave). The signal names match the controller's own command port.
interface sdram_cmd_responder_if
    import sdram_cmd_pkg::*;
#(
    parameter int DataWidth = DefDataWidth
);
    logic                    cmdReady;
    logic                    cmdTrigger;
    logic [CmdAddrWidth-1:0] cmdAddr;
    logic                    cmdWrite;
    logic [DataWidth-1:0]    cmdWriteData;
    logic [DataWidth-1:0]    cmdReadData;
    logic                    cmdReadDataValid;

    modport master (
        input  cmdReady, cmdReadData, cmdReadDataValid,
        output cmdTrigger, cmdAddr, cmdWrite, cmdWriteData
    );

    modport slave (
        output cmdReady, cmdReadData, cmdReadDataValid,
        input  cmdTrigger, cmdAddr, cmdWrite, cmdWriteData
    );
endinterface

// File: rtl/sdram_cmd_read_pipe.sv
// Fixed-latency, in-order read return pipe. It is ReadLatency stages deep and is flushed synchronously by rst.
// Each stage captures data only when its valid is set, so the output data holds its last value between returns.
module sdram_cmd_read_pipe #(
    parameter int DataWidth   = 16,
    parameter int ReadLatency = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 vld_o,
    output logic [DataWidth-1:0] data_o
);
    logic [ReadLatency-1:0]                vld_q, vld_d;
    logic [ReadLatency-1:0][DataWidth-1:0] data_q, data_d;

    always_comb begin
        vld_d     = '0;
        data_d    = '0;
        vld_d[0]  = vld_i;
        data_d[0] = data_i;
        for (int i = 1; i < ReadLatency; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < ReadLatency; i++) begin
                if (vld_d[i]) data_q[i] <= data_d[i];
            end
        end
    end

    assign vld_o  = vld_q[ReadLatency-1];
    assign data_o = data_q[ReadLatency-1];
endmodule

// File: rtl/sdram_cmd_responder.sv
// BRAM-backed stand-in for the SDRAM controller command port. Defining the macro
// SDRAM_CMD_RESPONDER_STALL_EN enables the init, refresh and row-miss stall emulation.
module sdram_cmd_responder
    import sdram_cmd_pkg::*;
#(
    parameter int AddrWidth       = 10,
    parameter int DataWidth       = DefDataWidth,
    parameter int ColWidth        = 8,
    parameter int ReadLatency     = 3,
    parameter int RefreshInterval = 64,
    parameter int RefreshCycles   = 4,
    parameter int RowMissPenalty  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_cmd_responder_if.slave  cmd_if
);
    state_e                 state_q, state_d;
    logic                   accept, rd_accept;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   rd_word;
    logic [DataWidth-1:0]   mem_q [2**AddrWidth];
    logic                   unused_addr_hi;

    // Address bits above the memory depth alias onto the same words.
    assign addr           = cmd_if.cmdAddr[AddrWidth-1:0];
    assign unused_addr_hi = ^cmd_if.cmdAddr[CmdAddrWidth-1:AddrWidth];

    assign cmd_if.cmdReady = (state_q == Ready);
    assign accept          = cmd_if.cmdReady && cmd_if.cmdTrigger;
    assign rd_accept       = accept && !cmd_if.cmdWrite;
    assign rd_word         = mem_q[addr];

    always_ff @(posedge clk) begin
        if (accept && cmd_if.cmdWrite) mem_q[addr] <= cmd_if.cmdWriteData;
    end

`ifdef SDRAM_CMD_RESPONDER_STALL_EN
    localparam int RowW = AddrWidth - ColWidth;
    localparam int CntW = $clog2(max_int(RefreshCycles, RowMissPenalty) + 1);
    localparam int RefW = $clog2(RefreshInterval + 1);
    localparam logic [RefW-1:0] RefLast = RefW'(RefreshInterval - 1);

    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
    logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
    logic [RowW-1:0] open_row_q, open_row_d, row;
    logic            row_valid_q, row_valid_d;
    logic            ref_due, row_miss, enter_ref;

    assign row      = cmd_if.cmdAddr[AddrWidth-1:ColWidth];
    assign ref_due  = (ref_cnt_q == RefLast);
    assign row_miss = !row_valid_q || (row != open_row_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= Refresh;
            stall_cnt_q <= CntW'(RefreshCycles);
            ref_cnt_q   <= '0;
            row_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            ref_cnt_q   <= ref_cnt_d;
            row_valid_q <= row_valid_d;
        end
        open_row_q <= open_row_d;
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        open_row_d  = open_row_q;
        row_valid_d = row_valid_q;
        ref_cnt_d   = ref_due ? ref_cnt_q : ref_cnt_q + RefW'(1);
        enter_ref   = 1'b0;
        case (state_q)
            Ready: begin
                if (accept && row_miss) begin
                    state_d     = RowOpen;
                    open_row_d  = row;
                    row_valid_d = 1'b1;
                    stall_cnt_d = CntW'(RowMissPenalty);
                end else if (ref_due) begin
                    enter_ref = 1'b1;
                end
            end
            RowOpen: begin
                if (stall_cnt_q == CntW'(1)) begin
                    if (ref_due) enter_ref = 1'b1;
                    else         state_d   = Ready;
                end else begin
                    stall_cnt_d = stall_cnt_q - CntW'(1);
                end
            end
            default: begin
                ref_cnt_d = ref_cnt_q;
                if (stall_cnt_q == CntW'(1)) state_d = Ready;
                else stall_cnt_d = stall_cnt_q - CntW'(1);
            end
        endcase
        // A refresh closes the open row and restarts the refresh interval.
        if (enter_ref) begin
            state_d     = Refresh;
            stall_cnt_d = CntW'(RefreshCycles);
            row_valid_d = 1'b0;
            ref_cnt_d   = '0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) state_q <= Refresh;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = Ready;
    end
`endif

    sdram_cmd_read_pipe #(
        .DataWidth   (DataWidth),
        .ReadLatency (ReadLatency)
    ) u_read_pipe (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (rd_accept),
        .data_i (rd_word),
        .vld_o  (cmd_if.cmdReadDataValid),
        .data_o (cmd_if.cmdReadData)
    );
endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Randomized bench for sdram_cmd_responder. It uses a behavioural model of the stall windows, memory and read returns.
// The bench follows SDRAM_CMD_RESPONDER_STALL_EN the same way the design does.
module tb_sdram_cmd_responder;
    localparam int AW = 10, DW = 16, CW = 8, RL = 3, RI = 64, RC = 4, RMP = 2;
`ifdef SDRAM_CMD_RESPONDER_STALL_EN
    localparam bit Stall   = 1'b1;
    localparam int InitWin = RC;
`else
    localparam bit Stall   = 1'b0;
    localparam int InitWin = 1;
`endif

    typedef struct { int due; logic [DW-1:0] d; } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_cmd_responder_if #(.DataWidth(DW)) bus ();

    sdram_cmd_responder #(
        .AddrWidth(AW), .DataWidth(DW), .ColWidth(CW), .ReadLatency(RL),
        .RefreshInterval(RI), .RefreshCycles(RC), .RowMissPenalty(RMP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd_if (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state
    logic [DW-1:0] mmem [1024];
    bit            written [1024];
    int            wr_list [$];
    ret_t          rq [$];
    logic [DW-1:0] last_data;
    bit  live = 1'b0, in_ref, row_open;
    int  wait_n, open_row, nonref, n_acc_rd = 0, n_vld = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic start_refresh();
        in_ref   = 1'b1;
        wait_n   = RC;
        row_open = 1'b0;
        nonref   = 0;
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model across the edge.
    task automatic tick(input bit t_rst, input bit trig, input bit wr,
                        input logic [22:0] a, input logic [DW-1:0] wd, output bit acc);
        bit exp_v, due;
        int idx, row;
        @(negedge clk);
        if (live) begin
            chk("ready", 32'(bus.cmdReady), 32'(wait_n == 0));
            exp_v = (rq.size() > 0) && (rq[0].due == cyc);
            chk("rvalid", 32'(bus.cmdReadDataValid), 32'(exp_v));
            if (bus.cmdReadDataValid) n_vld++;
            if (exp_v) begin
                chk("rdata", 32'(bus.cmdReadData), 32'(rq[0].d));
                last_data = rq[0].d;
                rq.delete(0);
            end else begin
                chk("rdata_hold", 32'(bus.cmdReadData), 32'(last_data));
            end
        end
        rst              = t_rst;
        bus.cmdTrigger   = trig;
        bus.cmdWrite     = wr;
        bus.cmdAddr      = a;
        bus.cmdWriteData = wd;
        acc = live && !t_rst && trig && (wait_n == 0);
        idx = int'(a[AW-1:0]);
        row = idx >> CW;
        if (t_rst) begin
            in_ref    = 1'b1;
            wait_n    = InitWin;
            row_open  = 1'b0;
            nonref    = 0;
            n_acc_rd -= rq.size();
            rq.delete();
            last_data = '0;
        end else begin
            if (acc && wr) begin
                mmem[idx] = wd;
                if (!written[idx]) wr_list.push_back(idx);
                written[idx] = 1'b1;
            end else if (acc) begin
                rq.push_back('{due: cyc + RL, d: mmem[idx]});
                n_acc_rd++;
            end
            due = (nonref >= RI - 1);
            if (in_ref) begin
                wait_n--;
                if (wait_n == 0) in_ref = 1'b0;
            end else if (Stall) begin
                if (nonref < RI - 1) nonref++;
                if (wait_n > 0) begin
                    wait_n--;
                    if (wait_n == 0 && due) start_refresh();
                end else if (acc && (!row_open || row != open_row)) begin
                    row_open = 1'b1;
                    open_row = row;
                    wait_n   = RMP;
                end else if (due) begin
                    start_refresh();
                end
            end
        end
        live = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0, acc);
    endtask

    // Holds the command until the model says it is taken, bounded by a cycle budget.
    task automatic issue(input bit wr, input logic [22:0] a, input logic [DW-1:0] wd);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 100) begin
            tick(1'b0, 1'b1, wr, a, wd, acc);
            n++;
        end
        chk("issue_accept", 32'(acc), 32'd1);
    endtask

    function automatic logic [22:0] pick_written();
        int idx = wr_list[$urandom_range(wr_list.size() - 1)];
        return {13'($urandom), 10'(idx)};
    endfunction

    initial begin
        bit acc, wr, trig;
        logic [22:0] a;
        logic [DW-1:0] wd;

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, '0, '0, acc);
        idle(8);

        // First write opens a row, then read back
        issue(1'b1, 23'h005, 16'hA55A);
        issue(1'b0, 23'h005, '0);
        idle(5);

        for (int i = 0; i < 4; i++) issue(1'b1, 23'(16 + i), 16'(16'h1111 * (i + 1)));
        for (int i = 0; i < 4; i++) issue(1'b0, 23'(16 + i), '0);
        idle(5);

        issue(1'b1, 23'h0FF, 16'h0F0F);
        issue(1'b1, 23'h100, 16'h1234);
        issue(1'b0, 23'h0FF, '0);
        issue(1'b0, 23'h100, '0);
        issue(1'b1, 23'h400, 16'hBEEF);
        issue(1'b0, 23'h000, '0);
        idle(6);

        // Trigger held continuously across several refresh windows
        a = pick_written();
        for (int i = 0; i < 200; i++) begin
            tick(1'b0, 1'b1, 1'b0, a, '0, acc);
            if (acc) a = ($urandom_range(7) == 0) ? {13'($urandom), 10'($urandom)} : pick_written();
            if (acc && !written[int'(a[AW-1:0])]) a = pick_written();
        end
        idle(6);

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            trig = ($urandom_range(3) != 0);
            wr   = ($urandom_range(9) < 3);
            wd   = 16'($urandom);
            a    = wr ? {13'($urandom), 10'($urandom)} : pick_written();
            tick(1'b0, trig, wr, a, wd, acc);
        end
        idle(6);

        // Reset with reads in flight
        issue(1'b0, 23'h010, '0);
        issue(1'b0, 23'h011, '0);
        tick(1'b1, 1'b0, 1'b0, '0, '0, acc);
        tick(1'b1, 1'b0, 1'b0, '0, '0, acc);
        idle(10);
        issue(1'b0, 23'h005, '0);
        issue(1'b0, 23'h013, '0);
        issue(1'b0, 23'h400, '0);
        idle(RL + 3);

        chk("acc_vs_vld", 32'(n_vld), 32'(n_acc_rd));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sdram_cmd_responder.md
# sdram_cmd_responder

Synthesizable, BRAM-backed responder for the SDRAM controller command interface (`cmdReady`/`cmdTrigger`/`cmdAddr`/`cmdWrite`/`cmdWriteData`/`cmdReadData`/`cmdReadDataValid`). It stands in for `SDRAMController` so that command initiators, such as the Iceboard SDRAM test harnesses, can run on-chip without an external SDRAM. It reproduces the controller's stall behaviour: init and refresh windows, and row-open penalties. It also reproduces fixed-latency, in-order read return.

## Interface
- `AddrWidth`, 10: backing memory depth is 2^AddrWidth words.
- `DataWidth`, 16: word width.
- `ColWidth`, 8: low address bits forming the column; bits [AddrWidth-1:ColWidth] form the row.
- `ReadLatency`, 3: cycles from read acceptance to `cmdReadDataValid`; must be ≥1.
- `RefreshInterval`, 64: non-refresh cycles between refresh windows.
- `RefreshCycles`, 4: length of a refresh window (also the post-reset init window).
- `RowMissPenalty`, 2: stall cycles after accepting a command to a closed row.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmdReady`  out  1  responder can accept a command this cycle.
- `cmdTrigger`  in  1  initiator presents a command.
- `cmdAddr`  in  23  word address; bits above AddrWidth ignored (aliasing).
- `cmdWrite`  in  1  1 = write, 0 = read.
- `cmdWriteData`  in  DataWidth  write data.
- `cmdReadData`  out  DataWidth  read data.
- `cmdReadDataValid`  out  1  `cmdReadData` valid this cycle.

## Operation
- Acceptance: a command is accepted on any edge where `cmdReady`=1 and `cmdTrigger`=1. Back-to-back acceptance is allowed while `cmdReady` stays 1. The initiator may hold `cmdTrigger` across non-ready cycles; nothing is lost or duplicated.
- Write: memory is updated at the acceptance edge. A read accepted on any later edge returns the new data.
- Read: the memory is sampled at the acceptance edge and the result enters the read pipe. Returns are strictly in order, with one valid pulse per accepted read. The pipe advances every cycle, independent of stalls.
- States: `Ready`, `RowOpen`, `Refresh`. `cmdReady` = (state==`Ready`), decoded from the state register.
  - `Ready` → `RowOpen` on acceptance when the row differs from the open row, or no row is open. The open row is updated and the stall counter loads RowMissPenalty.
  - `Ready` → `Refresh` when the refresh counter has reached RefreshInterval-1 and no row-miss acceptance occurs that edge. A command accepted on that edge is still accepted.
  - `RowOpen` → `Refresh` if refresh is due, otherwise → `Ready`, after RowMissPenalty cycles.
  - `Refresh` → `Ready` after RefreshCycles cycles. Entering `Refresh` closes the open row.
- Refresh counter: increments in `Ready`/`RowOpen`, saturates at RefreshInterval-1, clears on `Refresh` entry.
- Reset:
  - State = `Refresh` with a full RefreshCycles count, so `cmdReady`=0.
  - No row open; refresh counter 0.
  - Read pipe flushed: `cmdReadDataValid`=0, `cmdReadData`=0.
  - Memory contents retained.
  - Reads in flight when reset asserts never return.

## Timing
- Read accepted in cycle k → `cmdReadDataValid`=1 in cycle k+ReadLatency only. `cmdReadData` holds its last value otherwise.
- Row-miss acceptance in cycle k → `cmdReady`=0 in cycles k+1 … k+RowMissPenalty.
- Refresh window: `cmdReady`=0 for exactly RefreshCycles cycles.
- After `rst` falls: `cmdReady`=0 for RefreshCycles cycles, then 1.
- Throughput: one command per cycle within an open row, between refreshes.

## Configuration
- `SDRAM_CMD_RESPONDER_STALL_EN` defined:
  - Refresh windows and row-miss penalties are active as above.
- `SDRAM_CMD_RESPONDER_STALL_EN` undefined:
  - Zero-wait responder; `cmdReady`=1 from the first cycle after `rst` falls.
  - `cmdReady`=0 only during reset.
  - Refresh counter, stall counter and open-row logic are removed.
  - Read latency is unchanged.

## Structure
- Package `sdram_cmd_pkg`:
  - State enum (`Ready`/`RowOpen`/`Refresh`).
  - Command address width constant (23).
  - Default data width constant (16).
- Sub-module `sdram_cmd_read_pipe`:
  - ReadLatency-deep valid/data shift register with synchronous flush on `rst`.
- The top level holds the memory array, the state machine and the counters.

## Test plan
All scenarios use default parameters with the macro defined unless noted.
- Reset release → `cmdReady`=0 for 4 cycles, then 1. `cmdReadDataValid`=0 throughout.
- Write 0x005=0xA55A, then read 0x005 → `cmdReady`=0 for 2 cycles after the write (first open row). The read returns 0xA55A exactly 3 cycles after its acceptance.
- Writes 0x010..0x013 = 0x1111..0x4444, then `cmdTrigger` held for reads 0x010..0x013 → the 4 reads are accepted on consecutive edges. Valid goes high on 4 consecutive cycles with data in order.
- Read 0x0FF then 0x100 → `cmdReady` drops for 2 cycles after the second acceptance. Write 0x400=0xBEEF, then read 0x000 → 0xBEEF (aliasing).
- `cmdTrigger` held for 200 cycles of reads → a 4-cycle `cmdReady`=0 window occurs every 64 non-refresh cycles. A read accepted the edge before a refresh still returns on time. The accept count equals the valid count.
- Reset with 2 reads in flight → no valid pulse afterwards, and earlier writes still read back correctly. With the macro undefined, the same bench shows `cmdReady`=1 continuously after reset.
